// File: rtl/cordic_cmd_issue.sv
// Command issue stage: circular command queue feeding ex_top with one-cycle pulses,
// throttled by result-FIFO credits. Define CMD_ISSUE_STATS_EN for issue/stall counters.
module cordic_cmd_issue #(
   parameter int DATA_W  = 32,
   parameter int QDEPTH  = 4,
   parameter int QAW     = 2,
   parameter int CREDITS = 8,
   parameter int CW      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] in_interface,
   output logic              valid_in_interface,
   input  logic              result_pop,
   output logic [CW-1:0]     credits,
   output logic [QAW:0]      q_level,
   output logic              credit_err
`ifdef CMD_ISSUE_STATS_EN
   ,
   output logic [31:0]       stat_issued,
   output logic [31:0]       stat_stall
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

   localparam logic [QAW:0]   Q_FULL   = (QAW+1)'(QDEPTH);
   localparam logic [QAW:0]   Q_ONE    = (QAW+1)'(1);
   localparam logic [QAW-1:0] PTR_ONE  = QAW'(1);
   localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
   localparam logic [CW-1:0]  CRED_ONE = CW'(1);

   logic [DATA_W-1:0] queue [QDEPTH];
   logic [QAW-1:0]    wr_ptr;
   logic [QAW-1:0]    rd_ptr;
   state_t            state;
   state_t            st_next;
   logic [QAW:0]      q_next;
   logic [CW-1:0]     cr_next;
   logic              err_set;
   logic              push;
   logic              issue;

   assign cmd_ready = (q_level != Q_FULL);
   assign push      = cmd_valid & cmd_ready & ~flush;
   // The registered pulse blocks back-to-back issue, giving at most one issue per two cycles.
   assign issue     = (state == ISSUE) & (q_level != '0) & (credits != '0) &
                      ~flush & ~valid_in_interface;

   always_comb begin
      q_next  = q_level;
      cr_next = credits;
      err_set = 1'b0;
      st_next = state;

      if (flush)
         q_next = '0;
      else if (push & ~issue)
         q_next = q_level + Q_ONE;
      else if (~push & issue)
         q_next = q_level - Q_ONE;

      if (issue & ~result_pop)
         cr_next = credits - CRED_ONE;
      else if (~issue & result_pop) begin
         if (credits == CRED_MAX)
            err_set = 1'b1;
         else
            cr_next = credits + CRED_ONE;
      end

      // State follows the queue/credit levels it will see next cycle.
      if (flush || q_next == '0)
         st_next = IDLE;
      else if (cr_next == '0)
         st_next = STALL;
      else
         st_next = ISSUE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         q_level            <= '0;
         credits            <= CRED_MAX;
         credit_err         <= 1'b0;
         valid_in_interface <= 1'b0;
         in_interface       <= '0;
         state              <= IDLE;
      end else begin
         q_level            <= q_next;
         credits            <= cr_next;
         state              <= st_next;
         valid_in_interface <= issue;
         if (err_set)
            credit_err <= 1'b1;
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (flush)
            rd_ptr <= wr_ptr;
         else if (issue) begin
            rd_ptr       <= rd_ptr + PTR_ONE;
            in_interface <= queue[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         queue[wr_ptr] <= cmd_data;
   end

`ifdef CMD_ISSUE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (issue)
            stat_issued <= stat_issued + 32'd1;
         if (state == STALL)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cordic_cmd_issue.sv
// Directed bench for cordic_cmd_issue: queue, issue pacing, credits, flush and reset.
module tb_cordic_cmd_issue;

   logic        clk;
   logic        reset;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        flush;
   logic [31:0] in_interface;
   logic        valid_in_interface;
   logic        result_pop;
   logic [3:0]  credits;
   logic [2:0]  q_level;
   logic        credit_err;
`ifdef CMD_ISSUE_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_stall;
`endif

   int checks = 0;
   int errors = 0;
   int pulses;

   cordic_cmd_issue dut (
      .clk                (clk),
      .reset              (reset),
      .cmd_data           (cmd_data),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .flush              (flush),
      .in_interface       (in_interface),
      .valid_in_interface (valid_in_interface),
      .result_pop         (result_pop),
      .credits            (credits),
      .q_level            (q_level),
      .credit_err         (credit_err)
`ifdef CMD_ISSUE_STATS_EN
      ,
      .stat_issued        (stat_issued),
      .stat_stall         (stat_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, {31'd0, valid_in_interface}, 32'd0);
      check({tag, "_data"}, in_interface, 32'd0);
      check({tag, "_credits"}, {28'd0, credits}, 32'd8);
      check({tag, "_qlevel"}, {29'd0, q_level}, 32'd0);
      check({tag, "_err"}, {31'd0, credit_err}, 32'd0);
      check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   // Offers n sequential words, counting pulses and checking issue order.
   task automatic push_stream(input logic [31:0] base, input int n, output int npulse);
      int   pushed;
      logic rdy;
      pushed = 0;
      npulse = 0;
      for (int c = 0; c < 40; c++) begin
         cmd_valid = (pushed < n);
         cmd_data  = base + pushed;
         rdy       = cmd_ready;
         tick();
         if (cmd_valid && rdy)
            pushed++;
         if (valid_in_interface) begin
            check("stream_data", in_interface, base + npulse);
            npulse++;
         end
      end
      cmd_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] drain_exp [4];
      drain_exp[0] = 32'h0000_010A;
      drain_exp[1] = 32'h0000_010B;
      drain_exp[2] = 32'h0000_BEEF;
      drain_exp[3] = 32'h0000_DEAD;

      reset      = 1'b1;
      cmd_data   = '0;
      cmd_valid  = 1'b0;
      flush      = 1'b0;
      result_pop = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check_reset_values("reset");

      // Single push into an empty queue
      cmd_valid = 1'b1;
      cmd_data  = 32'h0000_1234;
      tick();
      cmd_valid = 1'b0;
      check("t1_qlevel_after_push", {29'd0, q_level}, 32'd1);
      check("t1_no_pulse_yet", {31'd0, valid_in_interface}, 32'd0);
      tick();
      check("t1_pulse", {31'd0, valid_in_interface}, 32'd1);
      check("t1_data", in_interface, 32'h0000_1234);
      check("t1_credits", {28'd0, credits}, 32'd7);
      check("t1_qlevel", {29'd0, q_level}, 32'd0);
      tick();
      check("t1_pulse_one_cycle", {31'd0, valid_in_interface}, 32'd0);
      check("t1_data_held", in_interface, 32'h0000_1234);
      result_pop = 1'b1;
      tick();
      result_pop = 1'b0;
      check("t1_credit_back", {28'd0, credits}, 32'd8);

      // Twelve words, no results returned: credit starvation
      push_stream(32'h0000_0100, 12, pulses);
      check("t2_pulse_count", pulses, 32'd8);
      check("t2_credits", {28'd0, credits}, 32'd0);
      check("t2_qlevel", {29'd0, q_level}, 32'd4);
      check("t2_ready", {31'd0, cmd_ready}, 32'd0);
      result_pop = 1'b1;
      tick();
      result_pop = 1'b0;
      check("t2_pop_credit", {28'd0, credits}, 32'd1);
      tick();
      check("t2_ninth_pulse", {31'd0, valid_in_interface}, 32'd1);
      check("t2_ninth_data", in_interface, 32'h0000_0108);
      check("t2_qlevel_after", {29'd0, q_level}, 32'd3);

      // Full queue refuses a push even in the cycle an issue frees a slot
      cmd_valid = 1'b1;
      cmd_data  = 32'h0000_BEEF;
      tick();
      check("t3_full", {29'd0, q_level}, 32'd4);
      check("t3_not_ready", {31'd0, cmd_ready}, 32'd0);
      cmd_data = 32'h0000_DEAD;
      tick();
      check("t3_refused", {29'd0, q_level}, 32'd4);
      result_pop = 1'b1;
      tick();
      result_pop = 1'b0;
      check("t3_still_full", {29'd0, q_level}, 32'd4);
      tick();
      check("t3_issue_pulse", {31'd0, valid_in_interface}, 32'd1);
      check("t3_issue_data", in_interface, 32'h0000_0109);
      check("t3_no_bypass", {29'd0, q_level}, 32'd3);
      tick();
      check("t3_accepted", {29'd0, q_level}, 32'd4);
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         result_pop = 1'b1;
         tick();
         result_pop = 1'b0;
         tick();
         check("t3_drain_pulse", {31'd0, valid_in_interface}, 32'd1);
         check("t3_drain_data", in_interface, drain_exp[i]);
      end
      check("t3_drained", {29'd0, q_level}, 32'd0);

      // Issue and result_pop in the same cycle
      result_pop = 1'b1;
      repeat (5) tick();
      result_pop = 1'b0;
      check("t4_credits5", {28'd0, credits}, 32'd5);
      cmd_valid = 1'b1;
      cmd_data  = 32'h0000_0055;
      tick();
      cmd_valid  = 1'b0;
      result_pop = 1'b1;
      tick();
      result_pop = 1'b0;
      check("t4_pulse", {31'd0, valid_in_interface}, 32'd1);
      check("t4_data", in_interface, 32'h0000_0055);
      check("t4_credits_same", {28'd0, credits}, 32'd5);

      // Credit overflow is sticky
      result_pop = 1'b1;
      repeat (3) tick();
      check("t5_credits_full", {28'd0, credits}, 32'd8);
      check("t5_no_err_yet", {31'd0, credit_err}, 32'd0);
      tick();
      result_pop = 1'b0;
      check("t5_saturate", {28'd0, credits}, 32'd8);
      check("t5_err_set", {31'd0, credit_err}, 32'd1);
      repeat (3) tick();
      check("t5_err_sticky", {31'd0, credit_err}, 32'd1);

      // Flush with a concurrent push, then reset while stalled
      push_stream(32'h0000_0200, 12, pulses);
      check("t6_pulse_count", pulses, 32'd8);
      result_pop = 1'b1;
      tick();
      result_pop = 1'b0;
      tick();
      check("t6_pre_flush_data", in_interface, 32'h0000_0208);
      check("t6_qlevel3", {29'd0, q_level}, 32'd3);
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_data  = 32'h0000_0077;
      tick();
      flush     = 1'b0;
      cmd_valid = 1'b0;
      check("t6_flushed", {29'd0, q_level}, 32'd0);
      check("t6_credits_kept", {28'd0, credits}, 32'd0);
      check("t6_ready", {31'd0, cmd_ready}, 32'd1);
      result_pop = 1'b1;
      tick();
      result_pop = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (valid_in_interface)
            pulses++;
      end
      check("t6_no_pulses", pulses, 32'd0);
      check("t6_qlevel_still0", {29'd0, q_level}, 32'd0);
      cmd_valid = 1'b1;
      cmd_data  = 32'h0000_0099;
      tick();
      cmd_data = 32'h0000_009A;
      tick();
      cmd_valid = 1'b0;
      check("t6_last_pulse", in_interface, 32'h0000_0099);
      tick();
      tick();
      check("t6_stall_q", {29'd0, q_level}, 32'd1);
      check("t6_stall_credits", {28'd0, credits}, 32'd0);
      check("t6_stall_no_pulse", {31'd0, valid_in_interface}, 32'd0);
      reset = 1'b1;
      tick();
      check_reset_values("t6_midstall_reset");
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (valid_in_interface)
            pulses++;
      end
      check("t6_queue_dropped", pulses, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
